// File: rtl/mux_scan_nx1.sv
// Registered CH:1 multiplexer of WIDTH-bit channels with a manual-select mode
// and an auto-scan mode that streams every channel over a valid/ready output.
`timescale 1ns/1ps
module mux_scan_nx1 #(
    parameter int WIDTH = 1,
    parameter int CH    = 16,
    parameter int SEL_W = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*WIDTH-1:0]   data_in,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  start,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = SEL_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [WIDTH-1:0]     data_r, data_s;
    logic [SEL_W-1:0]     ch_r, ch_s;
    logic                 valid_r, valid_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 accept_s;
    logic                 can_load_s;

    // Select one channel out of the flattened input bus.
    function automatic logic [WIDTH-1:0] pick(input logic [CH*WIDTH-1:0] bus,
                                              input logic [SEL_W-1:0]    idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            if (idx == SEL_W'(k)) begin
                r = bus[k*WIDTH +: WIDTH];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Handshake qualifiers shared by every state.
    always_comb begin
        accept_s   = valid_r & out_ready;
        can_load_s = ~valid_r | accept_s;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        data_s  = data_r;
        ch_s    = ch_r;
        valid_s = valid_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (!mode) begin
                    if (can_load_s) begin
                        data_s  = pick(data_in, sel);
                        ch_s    = sel;
                        valid_s = 1'b1;
                    end else begin
                        valid_s = valid_r;
                    end
                end else begin
                    // Drain any pending manual beat; a scan starts only from an empty output.
                    if (accept_s) begin
                        valid_s = 1'b0;
                    end else begin
                        valid_s = valid_r;
                    end
                    if (start && !valid_r) begin
                        state_s = ST_SCAN;
                        cnt_s   = '0;
                        busy_s  = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end
            ST_SCAN: begin
                if (can_load_s) begin
                    if (cnt_r < CNT_W'(CH)) begin
                        data_s  = pick(data_in, cnt_r[SEL_W-1:0]);
                        ch_s    = cnt_r[SEL_W-1:0];
                        valid_s = 1'b1;
                        cnt_s   = cnt_r + CNT_W'(1);
                    end else begin
                        // Counter already past CH-1, so this accept retired the last beat.
                        valid_s = 1'b0;
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        cnt_s   = '0;
                    end
                end else begin
                    valid_s = valid_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            data_r  <= '0;
            ch_r    <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            data_r  <= data_s;
            ch_r    <= ch_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign out_data  = data_r;
    assign out_ch    = ch_r;
    assign out_valid = valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench: a 16x1-bit instance for manual mode and a 4x8-bit instance for scan mode.
`timescale 1ns/1ps
module tb_mux_scan_nx1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=1, CH=16
    logic        rst_a;
    logic [15:0] din_a;
    logic        mode_a, start_a, rdy_a;
    logic [3:0]  sel_a;
    logic [0:0]  od_a;
    logic [3:0]  och_a;
    logic        ov_a, busy_a, done_a;

    // Instance B: WIDTH=8, CH=4
    logic        rst_b;
    logic [31:0] din_b;
    logic        mode_b, start_b, rdy_b;
    logic [1:0]  sel_b;
    logic [7:0]  od_b;
    logic [1:0]  och_b;
    logic        ov_b, busy_b, done_b;

    mux_scan_nx1 #(.WIDTH(1), .CH(16)) dut_a (
        .clk(clk), .rst_n(rst_a), .data_in(din_a), .mode(mode_a), .sel(sel_a),
        .start(start_a), .out_ready(rdy_a), .out_data(od_a), .out_ch(och_a),
        .out_valid(ov_a), .busy(busy_a), .done(done_a));

    mux_scan_nx1 #(.WIDTH(8), .CH(4)) dut_b (
        .clk(clk), .rst_n(rst_b), .data_in(din_b), .mode(mode_b), .sel(sel_b),
        .start(start_b), .out_ready(rdy_b), .out_data(od_b), .out_ch(och_b),
        .out_valid(ov_b), .busy(busy_b), .done(done_b));

    int errors = 0;
    int checks = 0;

    // Scan-side observation of instance B.
    int         acc_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] acc_log [0:7];
    logic [1:0] ach_log [0:7];

    always @(posedge clk) begin
        if (rst_b && ov_b && rdy_b) begin
            if (acc_cnt < 8) begin
                acc_log[acc_cnt] = od_b;
                ach_log[acc_cnt] = och_b;
            end
            acc_cnt = acc_cnt + 1;
        end
        if (rst_b && done_b) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] sel;
        logic       exp_d;
    } vec_t;
    vec_t tbl [16];

    logic [7:0] exp_bytes [4];
    logic [15:0] exp_seq;

    task automatic scan_start_b();
        acc_cnt  = 0;
        done_cnt = 0;
        mode_b   = 1'b1;
        start_b  = 1'b1;
        tick();
        start_b  = 1'b0;
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_accepts"}, acc_cnt, 4);
        chk({tag, "_dones"}, done_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_beat_data"}, acc_log[i], exp_bytes[i]);
            chk({tag, "_beat_ch"}, ach_log[i], i);
        end
    endtask

    initial begin
        exp_seq = 16'b1100_0011_1010_1101;   // expected bits for sel 0..15, MSB first
        for (int i = 0; i < 16; i++) begin
            tbl[i].sel   = 4'(i);
            tbl[i].exp_d = exp_seq[15-i];
        end
        exp_bytes[0] = 8'hAA; exp_bytes[1] = 8'hBB;
        exp_bytes[2] = 8'hCC; exp_bytes[3] = 8'hDD;

        rst_a = 1'b0; din_a = 16'b1011_0101_1100_0011; mode_a = 1'b0;
        sel_a = 4'd0; start_a = 1'b0; rdy_a = 1'b1;
        rst_b = 1'b0; din_b = 32'hDDCC_BBAA; mode_b = 1'b1;
        sel_b = 2'd0; start_b = 1'b0; rdy_b = 1'b1;
        tick();
        tick();
        chk("rst_a_valid", ov_a, 0);
        chk("rst_a_data", od_a, 0);
        chk("rst_b_valid", ov_b, 0);
        chk("rst_b_busy", busy_b, 0);
        chk("rst_b_done", done_b, 0);
        chk("rst_b_ch", och_b, 0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Manual sweep, one sel per cycle, one-cycle latency
        for (int i = 0; i < 16; i++) begin
            sel_a = tbl[i].sel;
            tick();
            chk("sweep_data", od_a, tbl[i].exp_d);
            chk("sweep_ch", och_a, tbl[i].sel);
            chk("sweep_valid", ov_a, 1);
        end

        // Manual stall: hold sel=3 beat while sel moves to 7
        sel_a = 4'd3;
        tick();
        chk("stall_load_ch", och_a, 3);
        rdy_a = 1'b0;
        sel_a = 4'd7;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hold_ch", och_a, 3);
            chk("stall_hold_data", od_a, 0);
            chk("stall_hold_valid", ov_a, 1);
        end
        rdy_a = 1'b1;
        tick();
        chk("stall_release_ch", och_a, 7);
        chk("stall_release_data", od_a, 1);

        // Manual start is ignored
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        chk("manual_start_busy", busy_a, 0);

        // Full scan with out_ready high
        scan_start_b();
        chk("scan_busy_start", busy_b, 1);
        chk("scan_valid_start", ov_b, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("scan_data", od_b, exp_bytes[i]);
            chk("scan_ch", och_b, i);
            chk("scan_valid", ov_b, 1);
            chk("scan_busy", busy_b, 1);
            chk("scan_no_done", done_b, 0);
        end
        tick();
        chk("scan_done", done_b, 1);
        chk("scan_busy_end", busy_b, 0);
        chk("scan_valid_end", ov_b, 0);
        tick();
        chk("scan_done_pulse", done_b, 0);
        check_log("scan");

        // Scan backpressure on the BB beat
        scan_start_b();
        tick();
        tick();
        chk("bp_ch1", och_b, 1);
        rdy_b = 1'b0;
        din_b = 32'h4433_2211;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", od_b, 8'hBB);
            chk("bp_hold_ch", och_b, 1);
        end
        din_b = 32'hDDCC_BBAA;
        rdy_b = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_idle_busy", busy_b, 0);
        check_log("bp");

        // Asynchronous reset during the channel-2 beat, then restart
        scan_start_b();
        tick();
        tick();
        tick();
        chk("rst_mid_ch2", och_b, 2);
        #2;
        rst_b = 1'b0;
        #1;
        chk("rst_mid_data", od_b, 0);
        chk("rst_mid_ch", och_b, 0);
        chk("rst_mid_valid", ov_b, 0);
        chk("rst_mid_busy", busy_b, 0);
        tick();
        chk("rst_mid_no_done", done_b, 0);
        rst_b = 1'b1;
        tick();
        chk("rst_mid_idle", busy_b, 0);
        scan_start_b();
        tick();
        chk("restart_ch0", och_b, 0);
        chk("restart_data", od_b, 8'hAA);
        for (int i = 0; i < 5; i++) tick();
        check_log("restart");

        // Start and mode changes during a scan are ignored
        scan_start_b();
        tick();
        start_b = 1'b1;
        mode_b  = 1'b0;
        tick();
        start_b = 1'b0;
        tick();
        chk("ign_ch2", och_b, 2);
        chk("ign_busy", busy_b, 1);
        for (int i = 0; i < 3; i++) tick();
        check_log("ign");
        // Back in IDLE with mode=0: start must not launch a scan
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        tick();
        chk("ign_manual_busy", busy_b, 0);
        chk("ign_manual_dones", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_nx1.md
Name: mux_scan_nx1

Overview:
- Parametrised, registered N:1 multiplexer. Generalises the 16:1 single-bit combinational mux to CH channels of WIDTH bits each.
- Adds a sequential auto-scan mode. Scan walks every channel in order and presents each one on a valid/ready output stream.
- Used wherever a bank of sources is sampled onto one bus: per-request in manual mode, or as a full sweep in scan mode.

Parameters:
- WIDTH, 1, bits per channel.
- CH, 16, number of channels. Power of 2, minimum 2.
- SEL_W, $clog2(CH), channel index width. Derived; do not override.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- data_in, input, CH*WIDTH, channel k occupies bits [k*WIDTH +: WIDTH].
- mode, input, 1, 0 = manual select, 1 = auto-scan. Sampled only in IDLE.
- sel, input, SEL_W, channel index for manual mode.
- start, input, 1, single-cycle request that begins a scan (mode=1, IDLE only).
- out_ready, input, 1, downstream accepts the current beat.
- out_data, output, WIDTH, registered selected channel data.
- out_ch, output, SEL_W, channel index of out_data.
- out_valid, output, 1, out_data/out_ch hold a beat.
- busy, output, 1, scan in progress.
- done, output, 1, one-cycle pulse after the final scan beat is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_data=0, out_ch=0, out_valid=0, busy=0, done=0; internal channel counter=0. Reset asserted mid-scan aborts the scan with no done pulse.
- Accept condition: a beat is accepted on a rising edge where out_valid=1 and out_ready=1.
- Load condition: "can_load" = out_valid=0 or accept.
- Stall rule: while out_valid=1 and out_ready=0, out_data and out_ch hold unchanged, even if data_in or sel change.
- State IDLE, mode=0 (manual):
  - on each can_load edge, out_data <= data_in[sel*WIDTH +: WIDTH], out_ch <= sel, out_valid <= 1;
  - latency is one cycle from sel/data_in to out_data;
  - start is ignored.
- State IDLE, mode=1:
  - no new beats are loaded;
  - a pending manual beat (out_valid=1) stays until accepted, then out_valid <= 0;
  - start=1 while out_valid=0 -> SCAN, counter=0, busy=1;
  - start=1 while out_valid=1 is ignored; start is not queued.
- State SCAN:
  - on each can_load edge with counter<=CH-1, load channel[counter] into out_data, set out_ch=counter and out_valid=1, then increment counter;
  - once channel CH-1 is loaded, no further loads occur;
  - acceptance of the CH-1 beat -> DONE, with out_valid <= 0;
  - data is sampled at load time, not at accept time;
  - mode, sel and start are ignored;
  - with out_ready held high, throughput is one beat per cycle: CH beats in CH cycles after the first load.
- State DONE: done=1 for exactly one cycle, busy=0, counter=0 -> IDLE.
- busy: 1 in SCAN only.
- Counter: SEL_W+1 bits, so there is no wrap ambiguity at CH-1.
- Mode change:
  - in manual operation, a mode change 0->1 takes effect the next cycle;
  - a mode change during SCAN has no effect until IDLE.
- Invalid sel: none is possible, because CH is a power of 2.

Test Plan:
- Manual sweep (WIDTH=1, CH=16, data_in=16'b1011_0101_1100_0011, out_ready=1, sel=0..15, one per cycle) -> one cycle after each sel, out_data=data_in[sel] and out_ch=sel; sequence 1,1,0,0,0,0,1,1,1,0,1,0,1,1,0,1.
- Manual stall: sel=3, out_valid=1, out_ready=0 for 4 cycles while sel changes to 7 -> out_data=0, out_ch=3 held; first cycle after out_ready=1, out_ch=7.
- Full scan (WIDTH=8, CH=4, data_in=32'hDDCC_BBAA, mode=1, start pulse, out_ready=1):
  - out_data=AA,BB,CC,DD with out_ch=0..3 on consecutive cycles;
  - done pulses once the cycle after the DD beat is accepted;
  - busy=1 throughout the scan.
- Scan backpressure: same setup, out_ready low for 3 cycles while out_ch=1 -> BB holds; no beat is skipped or duplicated; exactly 4 accepts and one done.
- Reset mid-scan: rst_n=0 asynchronously during the out_ch=2 beat -> all outputs 0 immediately, no done pulse; a subsequent start restarts the scan from channel 0.
- Ignored start: start pulsed during SCAN, and in mode=0 -> no restart, no extra done; the scan count remains 4.
